instr_fetch_sequencer: RTL

- Program sequencer for the 8-cycle-per-instruction CPU.
- Owns the program counter and reads 8-bit instructions from a synchronous instruction memory.
- Splits each instruction into the decoder fields and holds them stable for one full execution frame.
- Handles halt on HLT, single-step mode and stop requests; the decoder and datapath run off its frame timing.

---
 rtl/instr_fetch_sequencer_if.sv | 21 ++
 rtl/instr_fetch_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// Instruction memory read port shared by the fetch sequencer and a synchronous ROM.
// Read data is valid on the cycle after the read strobe.
interface instr_fetch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  Instr_mem_rd;
  logic [ADDR_WIDTH-1:0] Instr_mem_addr;
  logic [7:0]            Instr_mem_data;

  modport master (
    output Instr_mem_rd,
    output Instr_mem_addr,
    input  Instr_mem_data
  );

  modport slave (
    input  Instr_mem_rd,
    input  Instr_mem_addr,
    output Instr_mem_data
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Program sequencer: owns the PC, fetches one instruction per execution frame, holds the
// decoded fields stable through the frame and handles HLT, single-step and stop requests.
module instr_fetch_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned FRAME_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    Run,
  input  logic                    Stop,
  input  logic                    Step_mode,
  input  logic                    Step_go,
  instr_fetch_sequencer_if.master mem,
  output logic [2:0]              Opcode,
  output logic [2:0]              Operand_1_address,
  output logic                    Operand_2_type,
  output logic                    Operand_number,
  output logic                    Frame_start,
  output logic                    Exec_valid,
  output logic                    Halted,
  output logic [ADDR_WIDTH-1:0]   PC,
  output logic [7:0]              Instr_count
);

  localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_CYCLES - 1);
  localparam logic [2:0] OpHlt = 3'b111;
  localparam logic [7:0] IrReset = 8'hE0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StExec,
    StWaitStep,
    StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            ir_q, ir_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            icount_q, icount_d;
  logic                  stop_q, stop_d;
  logic                  stop_pend;

  // A stop seen this cycle counts as latched so a request on the last frame cycle is honoured.
  assign stop_pend = stop_q | Stop;

  // Next-state, PC/count update and stop-latch control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    icount_d = icount_q;
    stop_d   = stop_q;
    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (Run && !Stop) state_d = StFetch;
      end
      StFetch: begin
        stop_d  = stop_pend;
        state_d = StLoad;
      end
      StLoad: begin
        stop_d  = stop_pend;
        ir_d    = mem.Instr_mem_data;
        cnt_d   = '0;
        state_d = StExec;
      end
      StExec: begin
        stop_d = stop_pend;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (ir_q[7:5] == OpHlt) begin
            // HLT never retires: PC stays on the HLT word.
            state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
            if (icount_q != 8'hFF) icount_d = icount_q + 8'd1;
            if (stop_pend) begin
              state_d = StIdle;
              stop_d  = 1'b0;
            end else if (Step_mode) begin
              state_d = StWaitStep;
            end else begin
              state_d = StFetch;
            end
          end
        end
      end
      StWaitStep: begin
        if (Stop) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end else if (Step_go || !Step_mode) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (Stop) begin
          state_d = StIdle;
          stop_d  = 1'b0;
        end else if (Run) begin
          pc_d     = '0;
          icount_d = '0;
          state_d  = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ir_q     <= IrReset;
      cnt_q    <= '0;
      icount_q <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      icount_q <= icount_d;
      stop_q   <= stop_d;
    end
  end

  assign mem.Instr_mem_rd   = (state_q == StFetch);
  assign mem.Instr_mem_addr = pc_q;

  assign Exec_valid        = (state_q == StExec);
  assign Frame_start       = Exec_valid && (cnt_q == '0);
  assign Halted            = (state_q == StHalt);
  // Decoder sees HLT whenever no frame is executing.
  assign Opcode            = Exec_valid ? ir_q[7:5] : OpHlt;
  assign Operand_1_address = ir_q[4:2];
  assign Operand_2_type    = ir_q[1];
  assign Operand_number    = ir_q[0];
  assign PC                = pc_q;
  assign Instr_count       = icount_q;

endmodule
